// File: rtl/pc_fetch_if.sv
// Instruction-memory read bus between pc_fetch and memory.
// AXI-lite style AR/R channels, one read outstanding.
interface pc_fetch_if;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;

  modport master (
    output mem_arvalid,
    output mem_araddr,
    output mem_rready,
    input  mem_arready,
    input  mem_rvalid,
    input  mem_rdata,
    input  mem_rresp
  );

  modport slave (
    input  mem_arvalid,
    input  mem_araddr,
    input  mem_rready,
    output mem_arready,
    output mem_rvalid,
    output mem_rdata,
    output mem_rresp
  );
endinterface

// File: rtl/pc_fetch.sv
// Fetch PC generator and instruction-memory read master.
// Drains stale reads after redirects before refetching.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ERR_INST = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IF_ready,
  output logic        AR_valid,
  output logic [31:0] AR_inst,
  output logic [31:0] PC_snpc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  pc_fetch_if.master  mem
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP_AR,
    DROP_R
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] addr_q;
  logic [31:0] addr_d;
  logic        valid_d;
  logic [31:0] inst_d;
  logic [31:0] snpc_d;
  logic        ar_go;
  logic        r_go;
  logic [31:0] rd_word;

  assign ar_go   = mem.mem_arready;
  assign r_go    = mem.mem_rvalid;
  assign rd_word = (mem.mem_rresp == 2'b00)
                 ? mem.mem_rdata : ERR_INST;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = AR_valid;
    inst_d  = AR_inst;
    snpc_d  = PC_snpc;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ar_go) state_d = WAIT;
      end
      WAIT: begin
        if (r_go) begin
          state_d = HOLD;
          valid_d = 1'b1;
          inst_d  = rd_word;
          snpc_d  = pc_q + 32'd4;
        end
      end
      HOLD: begin
        if (IF_ready) begin
          state_d = REQ;
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
        end
      end
      DROP_AR: begin
        if (ar_go) state_d = DROP_R;
      end
      DROP_R: begin
        if (r_go) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides everything; the in-flight read is drained
    if (redirect) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      valid_d = 1'b0;
      inst_d  = AR_inst;
      snpc_d  = PC_snpc;
      unique case (state_q)
        IDLE, HOLD: state_d = REQ;
        REQ:  state_d = ar_go ? DROP_R : DROP_AR;
        WAIT: state_d = r_go ? REQ : DROP_R;
        default: ;
      endcase
    end
  end

  // Address only reloads on entry to REQ, so DROP_AR keeps it stable
  assign addr_d = (state_d == REQ) ? pc_d : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      AR_valid <= 1'b0;
      AR_inst  <= 32'd0;
      PC_snpc  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      AR_valid <= valid_d;
      AR_inst  <= inst_d;
      PC_snpc  <= snpc_d;
    end
  end

  always_comb begin
    mem.mem_arvalid = 1'b0;
    mem.mem_rready  = 1'b0;
    unique case (1'b1)
      (state_q == REQ),
      (state_q == DROP_AR): mem.mem_arvalid = 1'b1;
      (state_q == WAIT),
      (state_q == DROP_R):  mem.mem_rready  = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_araddr = addr_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a handshaking memory model.
// Expected addresses and outputs are queued and popped on events.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        IF_ready;
  logic        AR_valid;
  logic [31:0] AR_inst;
  logic [31:0] PC_snpc;
  logic        redirect;
  logic [31:0] redirect_pc;

  pc_fetch_if bus ();

  pc_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IF_ready    (IF_ready),
    .AR_valid    (AR_valid),
    .AR_inst     (AR_inst),
    .PC_snpc     (PC_snpc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ERR = 32'h0010_0073;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_ar[$];
  logic [63:0] exp_out[$];

  int          ar_dly = 0;
  int          r_dly = 0;
  logic [1:0]  resp_cfg = 2'b00;

  bit          busy = 0;
  bit          ar_fire = 0;
  bit          r_fire = 0;
  int          lat = 0;
  int          ar_cnt = 0;
  logic [31:0] fire_addr = 32'd0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h8000_0010;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'd0;
    bus.mem_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        ar_fire = 0;
        r_fire = 0;
        ar_cnt = 0;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
      end else begin
        if (r_fire) begin
          bus.mem_rvalid = 1'b0;
          busy = 0;
        end
        if (ar_fire) begin
          busy = 1;
          lat = r_dly;
        end
        bus.mem_arready = 1'b0;
        if (!busy && bus.mem_arvalid) begin
          if (ar_cnt >= ar_dly) begin
            bus.mem_arready = 1'b1;
            ar_cnt = 0;
          end else ar_cnt++;
        end
        if (busy && !bus.mem_rvalid) begin
          if (lat == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = word(fire_addr);
            bus.mem_rresp  = resp_cfg;
          end else lat--;
        end
        ar_fire = bus.mem_arvalid && bus.mem_arready;
        if (ar_fire) begin
          fire_addr = bus.mem_araddr;
          if (exp_ar.size() == 0)
            chk("ar_unexpected", fire_addr, 32'hxxxx_xxxx);
          else
            chk("araddr", fire_addr, exp_ar.pop_front());
        end
        r_fire = bus.mem_rvalid && bus.mem_rready;
      end
    end
  end

  task automatic expect_fetch(input logic [31:0] a,
                              input logic [31:0] inst);
    exp_ar.push_back(a);
    exp_out.push_back({inst, a + 32'd4});
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!AR_valid && n < 100);
    chk("wait_valid", 32'(AR_valid), 32'd1);
  endtask

  task automatic wait_rready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_rready && n < 50);
    chk("wait_rready", 32'(bus.mem_rready), 32'd1);
  endtask

  task automatic wait_arvalid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_arvalid && n < 50);
    chk("wait_arvalid", 32'(bus.mem_arvalid), 32'd1);
  endtask

  task automatic check_out();
    logic [63:0] e;
    if (exp_out.size() == 0) begin
      chk("out_unexpected", AR_inst, 32'hxxxx_xxxx);
    end else begin
      e = exp_out.pop_front();
      chk("AR_inst", AR_inst, e[63:32]);
      chk("PC_snpc", PC_snpc, e[31:0]);
    end
  endtask

  task automatic accept();
    IF_ready = 1'b1;
    @(posedge clk);
    #1 IF_ready = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(AR_valid), 32'd0);
    chk({tag, "_inst"}, AR_inst, 32'd0);
    chk({tag, "_snpc"}, PC_snpc, 32'd0);
    chk({tag, "_arvalid"}, 32'(bus.mem_arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(bus.mem_rready), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    IF_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    repeat (3) @(negedge clk);
    check_reset("rst");

    expect_fetch(32'h8000_0000, 32'h0000_0013);
    rst_n = 1'b1;
    wait_valid(n);
    chk("first_lat", n, 32'd3);
    check_out();

    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(AR_valid), 32'd1);
      chk("hold_inst", AR_inst, 32'h0000_0013);
      chk("hold_snpc", PC_snpc, 32'h8000_0004);
      chk("hold_arvalid", 32'(bus.mem_arvalid), 32'd0);
    end

    expect_fetch(32'h8000_0004, word(32'h8000_0004));
    expect_fetch(32'h8000_0008, word(32'h8000_0008));
    expect_fetch(32'h8000_000C, word(32'h8000_000C));
    IF_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      chk("stream_gap", n, 32'd3);
      check_out();
      if (i == 2) IF_ready = 1'b0;
    end

    r_dly = 4;
    exp_ar.push_back(32'h8000_0010);
    expect_fetch(32'h8000_0100, word(32'h8000_0100));
    accept();
    wait_rready();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0103;
    @(posedge clk);
    #1 redirect = 1'b0;
    r_dly = 0;
    wait_valid(n);
    check_out();

    ar_dly = 3;
    exp_ar.push_back(32'h8000_0104);
    expect_fetch(32'h8000_0200, word(32'h8000_0200));
    accept();
    wait_arvalid();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0200;
    @(posedge clk);
    #1 redirect = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("dropar_arvalid", 32'(bus.mem_arvalid), 32'd1);
      chk("dropar_addr", bus.mem_araddr, 32'h8000_0104);
    end
    wait_valid(n);
    check_out();
    ar_dly = 0;

    resp_cfg = 2'b10;
    exp_ar.push_back(32'h8000_0204);
    exp_out.push_back({ERR, 32'h8000_0208});
    accept();
    wait_valid(n);
    check_out();
    resp_cfg = 2'b00;

    expect_fetch(32'h8000_0300, word(32'h8000_0300));
    IF_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h8000_0300;
    @(posedge clk);
    #1;
    IF_ready = 1'b0;
    redirect = 1'b0;
    wait_valid(n);
    chk("redir_hold_lat", n, 32'd3);
    check_out();

    r_dly = 3;
    exp_ar.push_back(32'h8000_0304);
    expect_fetch(32'h8000_0400, word(32'h8000_0400));
    accept();
    wait_rready();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0500;
    @(posedge clk);
    #1 redirect_pc = 32'h8000_0400;
    r_dly = 0;
    @(posedge clk);
    #1 redirect = 1'b0;
    wait_valid(n);
    check_out();

    exp_ar.push_back(32'hFFFF_FFFC);
    exp_out.push_back({word(32'hFFFF_FFFC), 32'h0000_0000});
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 redirect = 1'b0;
    chk("redir_clears_valid", 32'(AR_valid), 32'd0);
    wait_valid(n);
    check_out();
    exp_ar.push_back(32'h0000_0000);
    exp_out.push_back({word(32'h0000_0000), 32'h0000_0004});
    accept();
    wait_valid(n);
    check_out();

    r_dly = 5;
    exp_ar.push_back(32'h0000_0004);
    accept();
    wait_rready();
    rst_n = 1'b0;
    #1 check_reset("async_rst");
    repeat (2) @(negedge clk);
    r_dly = 0;
    expect_fetch(32'h8000_0000, 32'h0000_0013);
    rst_n = 1'b1;
    wait_valid(n);
    chk("post_rst_lat", n, 32'd3);
    check_out();

    chk("ar_left", exp_ar.size(), 32'd0);
    chk("out_left", exp_out.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout observed=running expected=done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
